// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers; the top index is a read-only status word.
// Write AW/W halves are latched independently and commit together; the read path is independent.
module axi_lite_slave_regs #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       NUM_REGS  = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_2000
) (
    input  logic                       aclk,
    input  logic                       areset_n,
    input  logic [ADDR_W-1:0]          awaddr,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [DATA_W/8-1:0]        wstrb,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready,
    input  logic [ADDR_W-1:0]          araddr,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [DATA_W-1:0]          rdata,
    output logic [1:0]                 rresp,
    output logic                       rvalid,
    input  logic                       rready,
    input  logic [DATA_W-1:0]          i_status,
    output logic [NUM_REGS*DATA_W-1:0] o_regs
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return (off[1:0] == 2'b00) && ((off >> 2) < ADDR_W'(NUM_REGS));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return off[IDX_W+1:2];
    endfunction

    logic                aw_held_q, aw_held_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic                w_held_q, w_held_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];

    logic                aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [STRB_W-1:0]   wr_strb;
    logic [IDX_W-1:0]    wr_idx, rd_idx;
    logic                wr_ok;

    assign awready = !aw_held_q && !bvalid_q;
    assign wready  = !w_held_q && !bvalid_q;
    assign arready = !rvalid_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
        assign o_regs[k*DATA_W +: DATA_W] = regs_q[k];
    end

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    assign commit = (aw_hs || aw_held_q) && (w_hs || w_held_q);

    // A half latched earlier takes precedence over the live bus value.
    assign wr_addr = aw_held_q ? awaddr_q : awaddr;
    assign wr_data = w_held_q ? wdata_q : wdata;
    assign wr_strb = w_held_q ? wstrb_q : wstrb;
    assign wr_idx  = addr_idx(wr_addr);
    assign wr_ok   = addr_ok(wr_addr) && (wr_idx != STATUS_IDX);
    assign rd_idx  = addr_idx(araddr);

    always_comb begin
        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;

        if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
        end

        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (wr_ok) begin
                for (int unsigned b = 0; b < STRB_W; b++) begin
                    if (wr_strb[b]) begin
                        regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
            end
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                awaddr_d  = awaddr;
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                wdata_d  = wdata;
                wstrb_d  = wstrb;
            end
        end
    end

    // Reads sample regs_q, so a same-edge commit is not yet visible.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            if (!addr_ok(araddr)) begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end else begin
                rdata_d = (rd_idx == STATUS_IDX) ? i_status : regs_q[rd_idx];
                rresp_d = RESP_OKAY;
            end
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            aw_held_q <= 1'b0;
            awaddr_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            regs_q    <= '{default: '0};
        end else begin
            aw_held_q <= aw_held_d;
            awaddr_q  <= awaddr_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            regs_q    <= regs_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed plus randomized bench for axi_lite_slave_regs against an array-based register model.
module tb_axi_lite_slave_regs;

    logic         aclk = 1'b0;
    logic         areset_n;
    logic [31:0]  awaddr, wdata, araddr, rdata, i_status;
    logic [3:0]   wstrb;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [1:0]   bresp, rresp;
    logic [255:0] o_regs;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_regs [8];

    axi_lite_slave_regs #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(8), .BASE_ADDR(32'h0000_2000)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .i_status(i_status), .o_regs(o_regs)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Register k lives at byte address 0x2000 + 4k; only k < 7 is writable.
    function automatic logic rd_ok(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'h2000;
        return (off % 4 == 0) && (off / 4 < 8);
    endfunction

    function automatic logic wr_ok(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'h2000;
        return (off % 4 == 0) && (off / 4 < 7);
    endfunction

    function automatic logic [255:0] model_flat();
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v = v | (256'(m_regs[k]) << (32 * k));
        return v;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [31:0] st);
        if (!rd_ok(a)) return 32'h0;
        if ((a - 32'h2000) / 4 == 7) return st;
        return m_regs[(a - 32'h2000) / 4];
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        int          i;
        if (!wr_ok(a)) return;
        mask = '0;
        for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
        i = int'((a - 32'h2000) / 4);
        m_regs[i] = (m_regs[i] & ~mask) | (d & mask);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_regs[k] = '0;
    endtask

    // Drives AW after aw_dly cycles and W after w_dly cycles, checks the response, then drains B.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly);
        logic aw_done, w_done, aw_fire, w_fire;
        logic [1:0] exp_resp;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0;
        exp_resp = wr_ok(a) ? 2'b00 : 2'b10;
        while (!(aw_done && w_done) && cyc < 50) begin
            @(negedge aclk);
            awaddr = a; wdata = d; wstrb = s;
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            if (aw_done) chk("awready_held", awready, 1'b0);
            if (w_done)  chk("wready_held", wready, 1'b0);
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(posedge aclk);
            if (aw_fire) aw_done = 1;
            if (w_fire)  w_done = 1;
            cyc++;
        end
        #1;
        awvalid = 0; wvalid = 0;
        chk("wr_handshake_done", aw_done && w_done, 1'b1);
        model_write(a, d, s);
        chk("bvalid_after_commit", bvalid, 1'b1);
        chk("bresp", bresp, exp_resp);
        chk("o_regs_after_commit", o_regs, model_flat());
        for (int k = 0; k < b_dly; k++) begin
            @(negedge aclk);
            chk("bvalid_hold", bvalid, 1'b1);
            chk("bresp_hold", bresp, exp_resp);
            chk("awready_during_b", awready, 1'b0);
        end
        @(negedge aclk);
        bready = 1;
        @(posedge aclk);
        #1;
        bready = 0;
        chk("bvalid_cleared", bvalid, 1'b0);
    endtask

    // Issues AR, holds rready low r_dly cycles while perturbing i_status, then drains R.
    task automatic axi_read(input logic [31:0] a, input int r_dly);
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        @(negedge aclk);
        araddr = a; arvalid = 1;
        chk("arready_idle", arready, 1'b1);
        exp_d = model_read(a, i_status);
        exp_r = rd_ok(a) ? 2'b00 : 2'b10;
        @(posedge aclk);
        #1;
        arvalid = 0;
        chk("rvalid_after_ar", rvalid, 1'b1);
        chk("rdata", rdata, exp_d);
        chk("rresp", rresp, exp_r);
        for (int k = 0; k < r_dly; k++) begin
            @(negedge aclk);
            i_status = $urandom;
            chk("rvalid_hold", rvalid, 1'b1);
            chk("rdata_hold", rdata, exp_d);
            chk("arready_busy", arready, 1'b0);
        end
        @(negedge aclk);
        rready = 1;
        @(posedge aclk);
        #1;
        rready = 0;
        chk("rvalid_cleared", rvalid, 1'b0);
        chk("arready_after_r", arready, 1'b1);
    endtask

    logic [31:0] old_val, ra, wa, wd;
    logic [3:0]  ws;

    initial begin
        areset_n = 0;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0; i_status = '0;
        model_reset();
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_rresp", rresp, 2'b00);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_o_regs", o_regs, 256'h0);
        @(negedge aclk);
        areset_n = 1;
        chk("rst_awready", awready, 1'b1);
        chk("rst_wready", wready, 1'b1);
        chk("rst_arready", arready, 1'b1);

        axi_write(32'h2000, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        chk("t1_reg0", o_regs[31:0], 32'hDEADBEEF);
        axi_write(32'h2004, 32'h12345678, 4'b0011, 3, 0, 1);
        chk("t2_reg1", o_regs[63:32], 32'h00005678);
        axi_read(32'h2004, 4);

        axi_write(32'h201C, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        axi_write(32'h2020, 32'hFFFFFFFF, 4'hF, 1, 0, 0);
        axi_write(32'h2002, 32'hFFFFFFFF, 4'hF, 0, 2, 0);
        axi_write(32'h2008, 32'hCAFEF00D, 4'h0, 0, 0, 0);
        axi_read(32'h2020, 0);
        axi_read(32'h1FFC, 1);

        i_status = 32'hA5A5_0001;
        axi_read(32'h201C, 2);

        // Same-edge commit and read of reg 0 must return the pre-write contents.
        @(negedge aclk);
        old_val = m_regs[0];
        awaddr = 32'h2000; wdata = 32'h11112222; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 32'h2000; arvalid = 1;
        @(posedge aclk);
        #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        model_write(32'h2000, 32'h11112222, 4'hF);
        chk("t5_rd_old", rdata, old_val);
        chk("t5_bvalid", bvalid, 1'b1);
        chk("t5_rvalid", rvalid, 1'b1);
        chk("t5_o_regs", o_regs, model_flat());
        @(negedge aclk);
        bready = 1; rready = 1;
        @(posedge aclk);
        #1;
        bready = 0; rready = 0;
        chk("t5_b_clear", bvalid, 1'b0);
        chk("t5_r_clear", rvalid, 1'b0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0:       wa = 32'h2020 + 4 * $urandom_range(0, 3);
                1:       wa = 32'h2000 + $urandom_range(1, 3);
                2:       wa = 32'h1FFC;
                default: wa = 32'h2000 + 4 * $urandom_range(0, 7);
            endcase
            wd = $urandom;
            ws = 4'($urandom);
            axi_write(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            ra = ($urandom_range(0, 4) == 0) ? 32'h2021 : 32'h2000 + 4 * $urandom_range(0, 7);
            i_status = $urandom;
            axi_read(ra, $urandom_range(0, 3));
        end

        // Reset while B and R are both outstanding and unacknowledged.
        @(negedge aclk);
        awaddr = 32'h2008; wdata = 32'h55AA55AA; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 32'h2000; arvalid = 1;
        @(posedge aclk);
        #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("t6_bvalid_pending", bvalid, 1'b1);
        #2;
        areset_n = 0;
        #1;
        model_reset();
        chk("t6_bvalid_drop", bvalid, 1'b0);
        chk("t6_rvalid_drop", rvalid, 1'b0);
        chk("t6_o_regs", o_regs, 256'h0);
        @(negedge aclk);
        areset_n = 1;
        i_status = '0;
        for (int k = 0; k < 8; k++) axi_read(32'h2000 + 4 * k, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
